idex_bypass: RTL

// - ID/EX pipeline register with operand bypass; consumer of the hazard unit's halt/forward outputs.
// - Per operand, picks the source: EX ALU result, MEM ALU result, MEM load data, WB write-through or register file.
// - Registers the chosen operands with the rd/load tags into the EX stage.
// - Inserts a bubble on halt or flush, keeps a saturating bubble counter and flags illegal multi-hot forward selects.

---
 rtl/idex_bypass_pkg.sv | 25 ++
 rtl/idex_bypass_byp_mux.sv | 43 ++++
 rtl/idex_bypass.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/idex_bypass_pkg.sv
`default_nettype none
// ============================================================================
// Module : idex_bypass_pkg
// Brief  : Shared constants and helpers for the ID/EX bypass pipeline stage.
// Rev    : 1.0
// ============================================================================
package idex_bypass_pkg;

    localparam int c_XLEN       = 32;
    localparam int c_REG_ADDR_W = 5;
    localparam int c_FWD_W      = 3;

    localparam logic [c_REG_ADDR_W-1:0] c_X0_ADDR = '0;

    // Bit positions inside the packed per-operand forward-select vector
    localparam int c_FWD_ALU     = 0;
    localparam int c_FWD_MEM_ALU = 1;
    localparam int c_FWD_MEM     = 2;

    function automatic logic fwd_multi_hot(input logic [c_FWD_W-1:0] sel);
        return ($countones(sel) > 1);
    endfunction

endpackage : idex_bypass_pkg
`default_nettype wire

// File: rtl/idex_bypass_byp_mux.sv
`default_nettype none
// ============================================================================
// Module : byp_mux
// Brief  : Priority operand select: x0, EX ALU, MEM ALU, MEM load, WB, regfile.
// Rev    : 1.0
// ============================================================================
module byp_mux
    import idex_bypass_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic [c_REG_ADDR_W-1:0] i_raddr,
    input  logic [XLEN-1:0]         i_rdata,
    input  logic [c_FWD_W-1:0]      i_fwd,
    input  logic [XLEN-1:0]         i_ex_alu_res,
    input  logic [XLEN-1:0]         i_mem_alu_res,
    input  logic [XLEN-1:0]         i_mem_rdata,
    input  logic                    i_wb_wen,
    input  logic [c_REG_ADDR_W-1:0] i_wb_waddr,
    input  logic [XLEN-1:0]         i_wb_wdata,
    output logic [XLEN-1:0]         o_op,
    output logic                    o_multi_hot
);

    always_comb begin
        o_op = i_rdata;
        if (i_raddr == c_X0_ADDR) begin
            o_op = '0;
        end else if (i_fwd[c_FWD_ALU]) begin
            o_op = i_ex_alu_res;
        end else if (i_fwd[c_FWD_MEM_ALU]) begin
            o_op = i_mem_alu_res;
        end else if (i_fwd[c_FWD_MEM]) begin
            o_op = i_mem_rdata;
        end else if (i_wb_wen && (i_wb_waddr == i_raddr)) begin
            o_op = i_wb_wdata;
        end
    end

    assign o_multi_hot = fwd_multi_hot(i_fwd);

endmodule : byp_mux
`default_nettype wire

// File: rtl/idex_bypass.sv
`default_nettype none
// ============================================================================
// Module : idex_bypass
// Brief  : ID/EX pipeline register with operand bypass, bubble insertion,
//          saturating halt-bubble counter and sticky multi-hot forward flag.
// Rev    : 1.0
// ============================================================================
module idex_bypass
    import idex_bypass_pkg::*;
#(
    parameter int XLEN  = c_XLEN,
    parameter int CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_halt,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [c_REG_ADDR_W-1:0] i_rs1_raddr,
    input  logic [c_REG_ADDR_W-1:0] i_rs2_raddr,
    input  logic [XLEN-1:0]         i_rs1_rdata,
    input  logic [XLEN-1:0]         i_rs2_rdata,
    input  logic [c_REG_ADDR_W-1:0] i_rd_waddr,
    input  logic                    i_rd_wen,
    input  logic                    i_is_load,
    input  logic                    i_frwd_alu_op1,
    input  logic                    i_frwd_alu_op2,
    input  logic                    i_frwd_mem_alu_op1,
    input  logic                    i_frwd_mem_alu_op2,
    input  logic                    i_frwd_mem_op1,
    input  logic                    i_frwd_mem_op2,
    input  logic [XLEN-1:0]         i_ex_alu_res,
    input  logic [XLEN-1:0]         i_mem_alu_res,
    input  logic [XLEN-1:0]         i_mem_rdata,
    input  logic                    i_wb_wen,
    input  logic [c_REG_ADDR_W-1:0] i_wb_waddr,
    input  logic [XLEN-1:0]         i_wb_wdata,
    output logic                    o_ex_valid,
    output logic [XLEN-1:0]         o_ex_op1,
    output logic [XLEN-1:0]         o_ex_op2,
    output logic [c_REG_ADDR_W-1:0] o_ex_rd_waddr,
    output logic                    o_ex_rd_wen,
    output logic                    o_ex_is_load,
    output logic [CNT_W-1:0]        o_bubble_cnt,
    output logic                    o_fwd_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [c_FWD_W-1:0]      w_fwd_op1;
    logic [c_FWD_W-1:0]      w_fwd_op2;
    logic [XLEN-1:0]         w_op1;
    logic [XLEN-1:0]         w_op2;
    logic                    w_mh_op1;
    logic                    w_mh_op2;

    logic                    r_ex_valid;
    logic [XLEN-1:0]         r_ex_op1;
    logic [XLEN-1:0]         r_ex_op2;
    logic [c_REG_ADDR_W-1:0] r_ex_rd_waddr;
    logic                    r_ex_rd_wen;
    logic                    r_ex_is_load;
    logic [CNT_W-1:0]        r_bubble_cnt;
    logic                    r_fwd_err;

    always_comb begin
        w_fwd_op1                = '0;
        w_fwd_op1[c_FWD_ALU]     = i_frwd_alu_op1;
        w_fwd_op1[c_FWD_MEM_ALU] = i_frwd_mem_alu_op1;
        w_fwd_op1[c_FWD_MEM]     = i_frwd_mem_op1;
        w_fwd_op2                = '0;
        w_fwd_op2[c_FWD_ALU]     = i_frwd_alu_op2;
        w_fwd_op2[c_FWD_MEM_ALU] = i_frwd_mem_alu_op2;
        w_fwd_op2[c_FWD_MEM]     = i_frwd_mem_op2;
    end

    byp_mux #(.XLEN(XLEN)) u_byp_op1 (
        .i_raddr       (i_rs1_raddr),
        .i_rdata       (i_rs1_rdata),
        .i_fwd         (w_fwd_op1),
        .i_ex_alu_res  (i_ex_alu_res),
        .i_mem_alu_res (i_mem_alu_res),
        .i_mem_rdata   (i_mem_rdata),
        .i_wb_wen      (i_wb_wen),
        .i_wb_waddr    (i_wb_waddr),
        .i_wb_wdata    (i_wb_wdata),
        .o_op          (w_op1),
        .o_multi_hot   (w_mh_op1)
    );

    byp_mux #(.XLEN(XLEN)) u_byp_op2 (
        .i_raddr       (i_rs2_raddr),
        .i_rdata       (i_rs2_rdata),
        .i_fwd         (w_fwd_op2),
        .i_ex_alu_res  (i_ex_alu_res),
        .i_mem_alu_res (i_mem_alu_res),
        .i_mem_rdata   (i_mem_rdata),
        .i_wb_wen      (i_wb_wen),
        .i_wb_waddr    (i_wb_waddr),
        .i_wb_wdata    (i_wb_wdata),
        .o_op          (w_op2),
        .o_multi_hot   (w_mh_op2)
    );

    // Bubbles clear wen/is_load too, so the hazard unit never sees a phantom writer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_op1      <= '0;
            r_ex_op2      <= '0;
            r_ex_rd_waddr <= '0;
            r_ex_rd_wen   <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_bubble_cnt  <= '0;
            r_fwd_err     <= 1'b0;
        end else if (i_flush || i_halt) begin
            r_ex_valid    <= 1'b0;
            r_ex_op1      <= '0;
            r_ex_op2      <= '0;
            r_ex_rd_waddr <= '0;
            r_ex_rd_wen   <= 1'b0;
            r_ex_is_load  <= 1'b0;
            if (!i_flush && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else begin
            r_ex_valid    <= i_valid;
            r_ex_op1      <= w_op1;
            r_ex_op2      <= w_op2;
            r_ex_rd_waddr <= i_valid ? i_rd_waddr : '0;
            r_ex_rd_wen   <= i_valid & i_rd_wen;
            r_ex_is_load  <= i_valid & i_is_load;
            if (w_mh_op1 || w_mh_op2) begin
                r_fwd_err <= 1'b1;
            end
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_op1      = r_ex_op1;
    assign o_ex_op2      = r_ex_op2;
    assign o_ex_rd_waddr = r_ex_rd_waddr;
    assign o_ex_rd_wen   = r_ex_rd_wen;
    assign o_ex_is_load  = r_ex_is_load;
    assign o_bubble_cnt  = r_bubble_cnt;
    assign o_fwd_err     = r_fwd_err;

endmodule : idex_bypass
`default_nettype wire
